// File: rtl/signed_div_core_if.sv
// Handshake and operand/result bundle between the divider controller and signed_div_core.
interface signed_div_core_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_by_zero;

    modport master (
        output start, dvd_mag, dvs_mag, dvd_neg, dvs_neg,
        input  busy, done, quot, rem, div_by_zero
    );

    modport slave (
        input  start, dvd_mag, dvs_mag, dvd_neg, dvs_neg,
        output busy, done, quot, rem, div_by_zero
    );
endinterface

// File: rtl/signed_div_core.sv
// Sequential restoring divider on operand magnitudes, one quotient bit per clock,
// with truncating-division sign correction applied in a final FIX cycle.
module signed_div_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    signed_div_core_if.slave    bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [RW:0]      r_sh;
    logic             ge;
    logic [WIDTH-1:0] mag_rem;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            dvs_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            q_q       <= q_d;
            dvs_q     <= dvs_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

    // Next-state, restoring step and sign correction
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        q_d       = q_q;
        dvs_d     = dvs_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;

        // {R,Q} shifted left with the next dividend bit entering R
        r_sh    = {r_q, q_q[WIDTH-1]};
        ge      = (r_sh >= (RW+1)'(dvs_q));
        // On divide-by-zero Q still holds the untouched dividend
        mag_rem = zero_q ? q_q : r_q[WIDTH-1:0];

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_d       = bus.dvd_mag;
                    dvs_d     = bus.dvs_mag;
                    dvd_neg_d = bus.dvd_neg;
                    dvs_neg_d = bus.dvs_neg;
                    r_d       = '0;
                    cnt_d     = '0;
                    zero_d    = (bus.dvs_mag == '0);
                    busy_d    = 1'b1;
                    state_d   = (bus.dvs_mag == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                r_d   = ge ? RW'(r_sh - (RW+1)'(dvs_q)) : r_sh[RW-1:0];
                q_d   = {q_q[WIDTH-2:0], ge};
                cnt_d = CW'(cnt_q + 1'b1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quot_d = '1;
                end else begin
                    quot_d = (dvd_neg_q ^ dvs_neg_q) ? WIDTH'(WIDTH'(0) - q_q) : q_q;
                end
                rem_d   = dvd_neg_q ? WIDTH'(WIDTH'(0) - mag_rem) : mag_rem;
                dbz_d   = zero_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quot        = quot_q;
    assign bus.rem         = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_div_core.sv
// Directed-vector bench for signed_div_core: arithmetic, latency, handshake and reset abort.
module tb_signed_div_core;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    signed_div_core_if #(.WIDTH(WIDTH)) bus ();

    signed_div_core #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [15:0] dvd, input logic [15:0] dvs,
                           input logic dn, input logic sn);
        bus.dvd_mag = dvd;
        bus.dvs_mag = dvs;
        bus.dvd_neg = dn;
        bus.dvs_neg = sn;
    endtask

    // One division: start at E0, count edges to done, check results and pulse width
    task automatic run_div(input string tag,
                           input logic [15:0] dvd, input logic [15:0] dvs,
                           input logic dn, input logic sn, input int exp_lat,
                           input logic [15:0] eq, input logic [15:0] er, input logic edbz);
        int lat;
        set_ops(dvd, dvs, dn, sn);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (bus.done) break;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " quot"}, 32'(bus.quot), 32'(eq));
        check({tag, " rem"}, 32'(bus.rem), 32'(er));
        check({tag, " dbz"}, 32'(bus.div_by_zero), 32'(edbz));
        check({tag, " busy@done"}, 32'(bus.busy), 32'd0);
        tick();
        check({tag, " done fall"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int dones;
        int lat_first;
        int lat_second;

        bus.start = 1'b0;
        set_ops(16'd0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst quot", 32'(bus.quot), 32'd0);
        check("rst rem", 32'(bus.rem), 32'd0);
        check("rst dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_div("100/7",     16'd100,  16'd7, 1'b0, 1'b0, 17, 16'd14,   16'd2,    1'b0);
        run_div("-100/7",    16'd100,  16'd7, 1'b1, 1'b0, 17, 16'hFFF2, 16'hFFFE, 1'b0);
        run_div("100/-7",    16'd100,  16'd7, 1'b0, 1'b1, 17, 16'hFFF2, 16'd2,    1'b0);
        run_div("-100/-7",   16'd100,  16'd7, 1'b1, 1'b1, 17, 16'd14,   16'hFFFE, 1'b0);
        run_div("1234/0",    16'd1234, 16'd0, 1'b0, 1'b0, 1,  16'hFFFF, 16'd1234, 1'b0 | 1'b1);
        run_div("-5/0",      16'd5,    16'd0, 1'b1, 1'b0, 1,  16'hFFFF, 16'hFFFB, 1'b1);
        run_div("-32768/-1", 16'h8000, 16'd1, 1'b1, 1'b1, 17, 16'h8000, 16'd0,    1'b0);
        run_div("7/100",     16'd7,    16'd100, 1'b0, 1'b0, 17, 16'd0,  16'd7,    1'b0);
        run_div("65535/1",   16'hFFFF, 16'd1, 1'b0, 1'b0, 17, 16'hFFFF, 16'd0,    1'b0);

        // Second start pulse at E5 must be ignored
        set_ops(16'd100, 16'd7, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        dones = 0;
        lat_first = 0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 5) begin
                set_ops(16'd9, 16'd1, 1'b1, 1'b0);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (bus.done) begin
                dones++;
                if (lat_first == 0) lat_first = i;
            end
        end
        check("ignore dones", 32'(dones), 32'd1);
        check("ignore latency", 32'(lat_first), 32'd17);
        check("ignore quot", 32'(bus.quot), 32'd14);
        check("ignore rem", 32'(bus.rem), 32'd2);

        // Start held high: back-to-back with one idle cycle
        set_ops(16'd100, 16'd7, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        dones = 0;
        lat_first = 0;
        lat_second = 0;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (bus.done) begin
                dones++;
                if (lat_first == 0) lat_first = i;
                else lat_second = i;
            end
        end
        bus.start = 1'b0;
        check("b2b dones", 32'(dones), 32'd2);
        check("b2b first", 32'(lat_first), 32'd17);
        check("b2b second", 32'(lat_second), 32'd35);
        check("b2b quot", 32'(bus.quot), 32'd14);
        repeat (3) tick();
        check("b2b idle busy", 32'(bus.busy), 32'd0);

        // Reset at E8 aborts the division with no later done
        set_ops(16'd100, 16'd7, 1'b1, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort quot", 32'(bus.quot), 32'd0);
        check("abort rem", 32'(bus.rem), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);

        run_div("50/5", 16'd50, 16'd5, 1'b0, 1'b0, 17, 16'd10, 16'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
